rng: RTL and testbench



---
 rtl/rng.sv | 90 +++++++++
 tb/tb_rng.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rng.sv
// ---------------------------------------------------------------------------
// rng -- free-running 32-bit pseudo-random number generator
//
// Combines a 43-bit Fibonacci LFSR (taps 42, 41, 20, 1) with a 37-bit hybrid
// rule-90/150 cellular automaton (rule 150 on cell 27 only, cyclic
// boundaries). Each clock either reloads both registers from a seed or steps
// them. The output word is the XOR of the LFSR's low 32 bits with the CASR's
// high 32 bits.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset (lfsr = 1, casr = 1)
//   loadseed_i  load seed_i on the next rising edge instead of stepping
//   seed_i      32-bit seed; zero is replaced by 1 to avoid lock-up
//   number_o    current random word, combinational from the registers
// ---------------------------------------------------------------------------
module rng (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadseed_i,
    input  logic [31:0] seed_i,
    output logic [31:0] number_o
);

    localparam int LFSR_W     = 43;
    localparam int CASR_W     = 37;
    // The single rule-150 cell that breaks the symmetry of a pure rule-90 ring.
    localparam int CA150_CELL = 27;

    logic [LFSR_W-1:0] lfsr;
    logic [CASR_W-1:0] casr;
    logic [LFSR_W-1:0] lfsr_step;
    logic [CASR_W-1:0] casr_step;
    logic [LFSR_W-1:0] lfsr_seed;
    logic [CASR_W-1:0] casr_seed;
    logic              lfsr_fb;
    logic              seed_is_zero;

    // Next-state values for both the step and the load paths.
    // NOTE: every always_comb output gets a value at the top of the block so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lfsr_fb      = 1'b0;
        lfsr_step    = '0;
        casr_step    = '0;
        lfsr_seed    = '0;
        casr_seed    = '0;
        seed_is_zero = 1'b0;

        lfsr_fb   = lfsr[42] ^ lfsr[41] ^ lfsr[20] ^ lfsr[1];
        lfsr_step = {lfsr[LFSR_W-2:0], lfsr_fb};

        // Rule 90 on a ring: rotate-left supplies casr[i-1] (cell 0 sees cell
        // 36), rotate-right supplies casr[i+1] (cell 36 sees cell 0).
        casr_step = {casr[CASR_W-2:0], casr[CASR_W-1]} ^
                    {casr[0], casr[CASR_W-1:1]};
        // Rule 150 additionally folds in the cell's own value.
        casr_step[CA150_CELL] = casr_step[CA150_CELL] ^ casr[CA150_CELL];

        // A zero seed would freeze both generators at zero forever, so it
        // behaves exactly like reset instead.
        seed_is_zero = (seed_i == 32'h0);
        if (seed_is_zero) begin
            lfsr_seed = LFSR_W'(1);
            casr_seed = CASR_W'(1);
        end else begin
            lfsr_seed = {11'b0, seed_i};
            casr_seed = {5'b0, seed_i};
        end
    end

    // Reset has priority over load, load over step; a load cycle never steps.
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_W'(1);
            casr <= CASR_W'(1);
        end else if (loadseed_i) begin
            lfsr <= lfsr_seed;
            casr <= casr_seed;
        end else begin
            lfsr <= lfsr_step;
            casr <= casr_step;
        end
    end

    assign number_o = lfsr[31:0] ^ casr[CASR_W-1:5];

endmodule

// File: tb/tb_rng.sv
// ---------------------------------------------------------------------------
// tb_rng -- self-checking bench for rng
//
// A table of directed vectors (hand-computed expected words) covers free-run
// stepping, seed loads, the zero-seed substitute and continuous loading.
// Hand-written sequences cover asynchronous reset, reset dominating load,
// reset in mid-run, and a long run compared against an independent
// cell-by-cell reference model, with repeat and low-nibble coverage checks.
// ---------------------------------------------------------------------------
module tb_rng;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        loadseed_i = 1'b0;
    logic [31:0] seed_i     = 32'h0;
    logic [31:0] number_o;

    int checks = 0;
    int passed = 0;

    rng dut (
        .clk        (clk),
        .reset      (reset),
        .loadseed_i (loadseed_i),
        .seed_i     (seed_i),
        .number_o   (number_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        load;
        logic [31:0] seed;
        logic [31:0] exp;
    } vec_t;

    // Reference model, written per cell with explicit modular neighbours.
    logic [42:0] m_lfsr;
    logic [36:0] m_casr;

    function automatic logic [31:0] m_out();
        logic [31:0] r;
        for (int b = 0; b < 32; b++) r[b] = m_lfsr[b] ^ m_casr[b + 5];
        return r;
    endfunction

    task automatic m_reset();
        m_lfsr = 43'h1;
        m_casr = 37'h1;
    endtask

    task automatic m_step();
        logic        fb;
        logic [36:0] nc;
        fb = m_lfsr[42] ^ m_lfsr[41] ^ m_lfsr[20] ^ m_lfsr[1];
        m_lfsr = (m_lfsr << 1) | {42'b0, fb};
        for (int i = 0; i < 37; i++) begin
            nc[i] = m_casr[(i + 36) % 37] ^ m_casr[(i + 1) % 37];
            if (i == 27) nc[i] = nc[i] ^ m_casr[i];
        end
        m_casr = nc;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        else
            passed++;
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        int          mism;
        int          reps;
        logic [15:0] cov;
        logic [31:0] prev;

        vecs.push_back('{"step1",       1'b0, 32'h0,        32'h8000_0002});
        vecs.push_back('{"step2",       1'b0, 32'h0,        32'h4000_0005});
        vecs.push_back('{"seed_a0",     1'b1, 32'h0000_00A0, 32'h0000_00A5});
        vecs.push_back('{"seed_a0_step",1'b0, 32'h0,        32'h0000_0148});
        vecs.push_back('{"zero_seed",   1'b1, 32'h0,        32'h0000_0001});
        vecs.push_back('{"zero_step1",  1'b0, 32'h0,        32'h8000_0002});
        vecs.push_back('{"zero_step2",  1'b0, 32'h0,        32'h4000_0005});
        vecs.push_back('{"cont_s1",     1'b1, 32'h1,        32'h0000_0001});
        vecs.push_back('{"cont_s2",     1'b1, 32'h2,        32'h0000_0002});
        vecs.push_back('{"cont_s3",     1'b1, 32'h3,        32'h0000_0003});
        vecs.push_back('{"cont_ones",   1'b1, 32'hFFFF_FFFF, 32'hF800_0000});
        vecs.push_back('{"cont_a0",     1'b1, 32'h0000_00A0, 32'h0000_00A5});

        // Asynchronous reset with no clock edge yet (first rising edge at 5).
        #1 reset = 1'b0;
        #1 check("reset_no_clk", number_o, 32'h0000_0001);

        // Load requests are ignored while reset is held.
        loadseed_i = 1'b1;
        seed_i     = 32'h1234_5678;
        tick();
        tick();
        check("reset_over_load", number_o, 32'h0000_0001);

        // Release reset between edges; the next edge is the first step.
        reset      = 1'b1;
        loadseed_i = 1'b0;
        seed_i     = 32'h0;

        foreach (vecs[k]) begin
            loadseed_i = vecs[k].load;
            seed_i     = vecs[k].seed;
            tick();
            check(vecs[k].name, number_o, vecs[k].exp);
        end

        // Free-run 100 cycles, then reset mid-cycle without a clock edge.
        loadseed_i = 1'b0;
        seed_i     = 32'h0;
        for (int n = 0; n < 100; n++) tick();
        #2 reset = 1'b0;
        #1 check("reset_midrun", number_o, 32'h0000_0001);
        @(negedge clk);
        reset = 1'b1;
        m_reset();

        // The sequence restarts exactly as from power-up.
        tick();
        m_step();
        check("rerun_step1", number_o, 32'h8000_0002);
        tick();
        m_step();
        check("rerun_step2", number_o, 32'h4000_0005);

        // Long run against the reference model, plus output statistics.
        mism = 0;
        reps = 0;
        cov  = '0;
        prev = number_o;
        for (int n = 0; n < 10000; n++) begin
            tick();
            m_step();
            if (number_o !== m_out()) begin
                if (mism == 0)
                    $display("FAIL model_step %0d: got %08h, expected %08h",
                             n, number_o, m_out());
                mism++;
            end
            if (number_o === prev) reps++;
            cov[number_o[3:0]] = 1'b1;
            prev = number_o;
        end
        check("model_mismatches", 32'(mism), 32'd0);
        check("consecutive_repeats", 32'(reps), 32'd0);
        check("nibble_coverage", {16'h0, cov}, 32'h0000_FFFF);

        // Seeding after a long run still lands on the seeded word.
        loadseed_i = 1'b1;
        seed_i     = 32'h8000_0000;
        tick();
        check("late_seed", number_o, 32'h8400_0000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
